// File: rtl/bright_spot_locator.sv
`default_nettype none
// ============================================================================
// Module  : bright_spot_locator
// Brief   : Per-frame centroid of pixels at or above a brightness threshold,
//           divided sequentially during blanking and held until the next frame.
// Revision: 1.0
// ============================================================================
module bright_spot_locator #(
    parameter logic [11:0] THRESH    = 12'hC00,
    parameter int          IMG_W     = 640,
    parameter int          IMG_H     = 480,
    parameter int          MIN_COUNT = 16,
    parameter int          SUM_W     = 28
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic [11:0] iDATA,
    output logic [9:0]  driven_coordinates_x,
    output logic [8:0]  driven_coordinates_y,
    output logic        oCOORD_VALID,
    output logic        oFRAME_DONE,
    output logic        oOVERRUN
);

    localparam logic [10:0]        c_img_w     = 11'(IMG_W);
    localparam logic [10:0]        c_img_h     = 11'(IMG_H);
    localparam logic [18:0]        c_min_count = 19'(MIN_COUNT);
    localparam int                 c_bit_w     = $clog2(SUM_W);
    localparam logic [c_bit_w-1:0] c_last_bit  = c_bit_w'(SUM_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic                 fval_q;
    logic [SUM_W-1:0]     sum_x_q,   sum_x_d;
    logic [SUM_W-1:0]     sum_y_q,   sum_y_d;
    logic [18:0]          cnt_q,     cnt_d;
    logic [SUM_W-1:0]     num_q,     num_d;
    logic [SUM_W-1:0]     rem_q,     rem_d;
    logic [SUM_W-1:0]     op_y_q,    op_y_d;
    logic [18:0]          den_q,     den_d;
    logic [9:0]           quo_q,     quo_d;
    logic [9:0]           quo_x_q,   quo_x_d;
    logic [c_bit_w-1:0]   bit_q,     bit_d;
    logic                 target_q,  target_d;
    logic [9:0]           coord_x_q, coord_x_d;
    logic [8:0]           coord_y_q, coord_y_d;
    logic                 valid_q,   valid_d;
    logic                 done_q,    done_d;
    logic                 overrun_q, overrun_d;

    logic                 w_qualify;
    logic                 w_frame_end;
    logic [SUM_W-1:0]     w_rem_shift;
    logic                 w_fits;
    logic [SUM_W-1:0]     w_rem_next;
    logic [9:0]           w_quo_next;

    always_comb begin
        w_qualify   = iFVAL & iDVAL & (iX_Cont < c_img_w) & (iY_Cont < c_img_h)
                    & (iDATA >= THRESH);
        w_frame_end = ~iFVAL & fval_q;
        // Remainder stays below the 19-bit divisor, so one SUM_W register suffices.
        // Only the low 10 quotient bits are ever needed, so older bits shift out.
        w_rem_shift = (rem_q << 1) | SUM_W'(num_q[SUM_W-1]);
        w_fits      = (w_rem_shift >= SUM_W'(den_q));
        w_rem_next  = w_fits ? (w_rem_shift - SUM_W'(den_q)) : w_rem_shift;
        w_quo_next  = (quo_q << 1) | 10'(w_fits);
    end

    always_comb begin
        state_d   = state_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        rem_d     = rem_q;
        op_y_d    = op_y_q;
        den_d     = den_q;
        quo_d     = quo_q;
        quo_x_d   = quo_x_q;
        bit_d     = bit_q;
        target_d  = target_q;
        coord_x_d = coord_x_q;
        coord_y_d = coord_y_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;

        if (w_frame_end) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else if (w_qualify) begin
            sum_x_d = sum_x_q + SUM_W'(iX_Cont);
            sum_y_d = sum_y_q + SUM_W'(iY_Cont);
            cnt_d   = cnt_q + 19'd1;
        end

        if (w_frame_end && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_frame_end) begin
                    num_d  = sum_x_q;
                    op_y_d = sum_y_q;
                    den_d  = cnt_q;
                    rem_d  = '0;
                    quo_d  = '0;
                    bit_d  = '0;
                    if (cnt_q < c_min_count) begin
                        target_d = 1'b0;
                        state_d  = COMMIT;
                    end else begin
                        target_d = 1'b1;
                        state_d  = DIV_X;
                    end
                end
            end
            DIV_X: begin
                num_d = num_q << 1;
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                bit_d = bit_q + c_bit_w'(1);
                if (bit_q == c_last_bit) begin
                    quo_x_d = w_quo_next;
                    num_d   = op_y_q;
                    rem_d   = '0;
                    quo_d   = '0;
                    bit_d   = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                num_d = num_q << 1;
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                bit_d = bit_q + c_bit_w'(1);
                if (bit_q == c_last_bit) begin
                    bit_d   = '0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                done_d  = 1'b1;
                valid_d = target_q;
                if (target_q) begin
                    coord_x_d = quo_x_q;
                    coord_y_d = quo_q[8:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            fval_q    <= 1'b0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            cnt_q     <= '0;
            num_q     <= '0;
            rem_q     <= '0;
            op_y_q    <= '0;
            den_q     <= '0;
            quo_q     <= '0;
            quo_x_q   <= '0;
            bit_q     <= '0;
            target_q  <= 1'b0;
            coord_x_q <= '0;
            coord_y_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fval_q    <= iFVAL;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            op_y_q    <= op_y_d;
            den_q     <= den_d;
            quo_q     <= quo_d;
            quo_x_q   <= quo_x_d;
            bit_q     <= bit_d;
            target_q  <= target_d;
            coord_x_q <= coord_x_d;
            coord_y_q <= coord_y_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign driven_coordinates_x = coord_x_q;
    assign driven_coordinates_y = coord_y_q;
    assign oCOORD_VALID         = valid_q;
    assign oFRAME_DONE          = done_q;
    assign oOVERRUN             = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_bright_spot_locator.sv
`default_nettype none
// ============================================================================
// Module  : tb_bright_spot_locator
// Brief   : Directed frame vectors with hand-computed centroids for bright_spot_locator.
// Revision: 1.0
// ============================================================================
module tb_bright_spot_locator;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFVAL;
    logic        iDVAL;
    logic [10:0] iX_Cont;
    logic [10:0] iY_Cont;
    logic [11:0] iDATA;
    logic [9:0]  driven_coordinates_x;
    logic [8:0]  driven_coordinates_y;
    logic        oCOORD_VALID;
    logic        oFRAME_DONE;
    logic        oOVERRUN;

    typedef struct {
        int bx;  int by;  int bw;  int bh;  int bval;
        int ex;  int ey;  int n_ex;
        int valid; int x; int y; int lat;
    } frame_t;

    frame_t tbl [9];

    int n_vec       = 0;
    int n_bad       = 0;
    int edge_no     = 0;
    int n_done_seen = 0;
    int n_ovr_seen  = 0;
    int lat;

    always #5 iCLK = ~iCLK;

    bright_spot_locator dut (
        .iCLK                 (iCLK),
        .iRST                 (iRST),
        .iFVAL                (iFVAL),
        .iDVAL                (iDVAL),
        .iX_Cont              (iX_Cont),
        .iY_Cont              (iY_Cont),
        .iDATA                (iDATA),
        .driven_coordinates_x (driven_coordinates_x),
        .driven_coordinates_y (driven_coordinates_y),
        .oCOORD_VALID         (oCOORD_VALID),
        .oFRAME_DONE          (oFRAME_DONE),
        .oOVERRUN             (oOVERRUN)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one pixel, let one rising edge consume it, then observe outputs.
    task automatic pix(input logic f, input logic dv, input int x, input int y, input int d);
        iFVAL   = f;
        iDVAL   = dv;
        iX_Cont = 11'(x);
        iY_Cont = 11'(y);
        iDATA   = 12'(d);
        @(posedge iCLK);
        #1;
        edge_no++;
        if (oFRAME_DONE) n_done_seen++;
        if (oOVERRUN)    n_ovr_seen++;
    endtask

    // Blanking carries bright, in-range, valid-flagged pixels that must be ignored.
    task automatic blank(input int n);
        repeat (n) pix(1'b0, 1'b1, 5, 5, 'hFFF);
    endtask

    task automatic send_body(input frame_t v);
        pix(1'b1, 1'b0, v.bx, v.by, 'hFFF);
        pix(1'b1, 1'b1, v.bx + v.bw, v.by, 'h000);
        for (int j = 0; j < v.bh; j++)
            for (int i = 0; i < v.bw; i++)
                pix(1'b1, 1'b1, v.bx + i, v.by + j, v.bval);
        for (int n = 0; n < v.n_ex; n++)
            pix(1'b1, 1'b1, v.ex, v.ey, 'hFFF);
    endtask

    task automatic end_frame();
        blank(1);
        edge_no     = 0;
        n_done_seen = 0;
        n_ovr_seen  = 0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        while (l < 0 && edge_no < 100) begin
            blank(1);
            if (oFRAME_DONE) l = edge_no;
        end
    endtask

    task automatic chk_outputs(input string tag, input int v, input int x, input int y);
        chk({tag, "_valid"}, int'(oCOORD_VALID), v);
        chk({tag, "_x"}, int'(driven_coordinates_x), x);
        chk({tag, "_y"}, int'(driven_coordinates_y), y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //          bx   by  bw bh bval    ex   ey  n_ex v  x    y    lat
        tbl[0] = '{100, 200, 4, 4, 'hFFF,   0,   0,  0, 1, 101, 201, 57};
        tbl[1] = '{100, 200, 5, 2, 'hFFF,   0,   0,  0, 0, 101, 201,  1};
        tbl[2] = '{300, 100, 4, 4, 'hBFF,   0,   0,  0, 0, 101, 201,  1};
        tbl[3] = '{300, 100, 4, 4, 'hC00,   0,   0,  0, 1, 301, 101, 57};
        tbl[4] = '{100, 200, 4, 4, 'hFFF, 700, 201, 16, 1, 101, 201, 57};
        tbl[5] = '{636, 476, 4, 4, 'hFFF, 640, 477, 16, 1, 637, 477, 57};
        tbl[6] = '{  0,   0, 4, 4, 'hFFF,  10, 480, 16, 1,   1,   1, 57};
        tbl[7] = '{ 20,  30, 5, 3, 'hFFF,   0,   0,  0, 0,   1,   1,  1};
        tbl[8] = '{ 50,  60, 8, 2, 'hFFF,   0,   0,  0, 1,  53,  60, 57};

        iRST = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0;
        iX_Cont = '0; iY_Cont = '0; iDATA = '0;
        repeat (3) @(posedge iCLK);
        #1;
        chk_outputs("reset", 0, 0, 0);
        chk("reset_done", int'(oFRAME_DONE), 0);
        chk("reset_overrun", int'(oOVERRUN), 0);
        iRST = 1'b0;
        blank(2);

        for (int i = 0; i < 9; i++) begin
            send_body(tbl[i]);
            end_frame();
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk_outputs($sformatf("v%0d", i), tbl[i].valid, tbl[i].x, tbl[i].y);
            blank(1);
            chk($sformatf("v%0d_done_pulse", i), int'(oFRAME_DONE), 0);
            chk($sformatf("v%0d_no_overrun", i), n_ovr_seen, 0);
            blank(3);
        end

        // Second frame ends while the first is still dividing.
        send_body(tbl[0]);
        end_frame();
        for (int k = 0; k < 16; k++) pix(1'b1, 1'b1, 10, 10, 'hFFF);
        for (int k = 0; k < 3; k++)  pix(1'b1, 1'b1, 12, 12, 'h000);
        blank(1);
        chk("t5_frame_end_edge", edge_no, 20);
        chk("t5_overrun_pulse", int'(oOVERRUN), 1);
        while (edge_no < 57) blank(1);
        chk("t5_done_at_57", int'(oFRAME_DONE), 1);
        chk_outputs("t5_first", 1, 101, 201);
        chk("t5_overrun_count", n_ovr_seen, 1);
        blank(80);
        chk("t5_single_commit", n_done_seen, 1);
        for (int k = 0; k < 16; k++) pix(1'b1, 1'b1, 10, 10, 'hFFF);
        end_frame();
        wait_done(lat);
        chk("t5_third_latency", lat, 57);
        chk_outputs("t5_third", 1, 10, 10);
        blank(3);

        // Asynchronous reset in the middle of the second divide.
        send_body(tbl[0]);
        end_frame();
        blank(40);
        #2;
        iRST = 1'b1;
        #1;
        chk_outputs("t6_reset", 0, 0, 0);
        chk("t6_reset_done", int'(oFRAME_DONE), 0);
        chk("t6_reset_overrun", int'(oOVERRUN), 0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        n_done_seen = 0;
        blank(60);
        chk("t6_no_stale_commit", n_done_seen, 0);
        send_body(tbl[0]);
        end_frame();
        wait_done(lat);
        chk("t6_latency", lat, 57);
        chk_outputs("t6_after", 1, 101, 201);
        blank(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
